// File: rtl/mac_frame_fifo.sv
// -----------------------------------------------------------------------------
// mac_frame_fifo
//   Store-and-forward frame FIFO for a MAC datapath. Words of DATA_IN_WIDTH
//   are written as frames delimited by start/end flags. A frame becomes
//   readable only when its end word is accepted. Each stored word is read out
//   as RATIO = DATA_IN_WIDTH/DATA_OUT_WIDTH beats, most significant beat first.
//   The input side can abort a frame, and the output side can retry a frame.
//   A frame that overflows storage is discarded when its end word arrives.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   data_in*            : write word plus enable/start/end/abort strobes
//   data_out            : registered output beat
//   data_out_enable     : pop strobe; data_out_valid marks a beat delivered
//   data_out_start/end  : first beat of a frame / last beat of a frame
//   retry               : rewind the output frame in progress to its first beat
//   fifo_full           : storage holds 2**FIFO_DEPTH unreleased words
//   frame_count         : committed frames not yet fully read (saturating)
//   overflow_drop       : one-cycle pulse when an overflowed frame is dropped
// -----------------------------------------------------------------------------
module mac_frame_fifo #(
  parameter int DATA_IN_WIDTH     = 32,
  parameter int DATA_OUT_WIDTH    = 8,
  parameter int FIFO_DEPTH        = 4,
  parameter int FRAME_COUNT_WIDTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_IN_WIDTH-1:0]     data_in,
  input  logic                         data_in_enable,
  input  logic                         data_in_start,
  input  logic                         data_in_end,
  input  logic                         data_in_abort,
  output logic [DATA_OUT_WIDTH-1:0]    data_out,
  input  logic                         data_out_enable,
  output logic                         data_out_valid,
  output logic                         data_out_start,
  output logic                         data_out_end,
  input  logic                         retry,
  output logic                         fifo_full,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         overflow_drop
);

  localparam int RATIO   = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int ENTRIES = 2 ** FIFO_DEPTH;
  localparam int PTR_W   = FIFO_DEPTH + 1;
  localparam int LANE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [PTR_W-1:0]             PTR_ENTRIES = PTR_W'(ENTRIES);
  localparam logic [LANE_W-1:0]            LAST_LANE   = LANE_W'(RATIO - 1);
  localparam logic [FRAME_COUNT_WIDTH-1:0] COUNT_MAX   = '1;

  typedef struct packed {
    logic                     sof;
    logic                     eof;
    logic [DATA_IN_WIDTH-1:0] data;
  } entry_t;

  // Storage
  entry_t r_mem [ENTRIES];

  // Write side state
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_frame_start_ptr;
  logic [PTR_W-1:0] r_commit_ptr;
  logic             r_in_frame;
  logic             r_overflow;

  // Read side state
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_release_ptr;
  logic [LANE_W-1:0] r_lane;
  logic              r_out_active;

  // Registered outputs
  logic [DATA_OUT_WIDTH-1:0]    r_data_out;
  logic                         r_data_out_valid;
  logic                         r_data_out_start;
  logic                         r_data_out_end;
  logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;
  logic                         r_overflow_drop;

  // ---------------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------------
  logic             w_accept;
  logic [PTR_W-1:0] w_base;
  logic [PTR_W-1:0] w_base_inc;
  logic [PTR_W-1:0] w_new_start;
  logic [PTR_W-1:0] w_base_used;
  logic [PTR_W-1:0] w_used;
  logic             w_drop;
  logic             w_mem_we;
  logic             w_commit;
  logic             w_discard;

  // Only words inside a frame (or opening one) are considered; abort wins.
  assign w_accept    = data_in_enable && !data_in_abort && (data_in_start || r_in_frame);
  // A start arriving mid-frame reuses the slot of the abandoned frame.
  assign w_base      = (data_in_start && r_in_frame) ? r_frame_start_ptr : r_wr_ptr;
  assign w_base_inc  = w_base + 1'b1;
  assign w_new_start = data_in_start ? w_base : r_frame_start_ptr;
  // Fullness is judged against the release pointer, so words of a frame that
  // is still being read out keep their storage until its end beat leaves.
  assign w_base_used = w_base - r_release_ptr;
  assign w_used      = r_wr_ptr - r_release_ptr;
  // Once a frame has lost a word it keeps dropping until a new start.
  assign w_drop      = w_accept && ((w_base_used == PTR_ENTRIES) ||
                                    (r_overflow && !data_in_start));
  assign w_mem_we    = w_accept && !w_drop;
  assign w_commit    = w_mem_we && data_in_end;
  assign w_discard   = w_drop && data_in_end;

  // ---------------------------------------------------------------------------
  // Read-side decode
  // ---------------------------------------------------------------------------
  entry_t                    w_rd_word;
  logic [DATA_IN_WIDTH-1:0]  w_shifted;
  logic [DATA_OUT_WIDTH-1:0] w_beat;
  logic                      w_out_retry;
  logic                      w_pop;
  logic                      w_last_lane;
  logic                      w_release;

  assign w_rd_word   = r_mem[r_rd_ptr[FIFO_DEPTH-1:0]];
  // Lane 0 is the most significant slice of the word.
  assign w_shifted   = w_rd_word.data << (r_lane * DATA_OUT_WIDTH);
  assign w_beat      = w_shifted[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];
  assign w_last_lane = (r_lane == LAST_LANE);
  assign w_out_retry = retry && r_out_active;
  assign w_pop       = data_out_enable && !w_out_retry &&
                       ((r_frame_count != '0) || r_out_active) &&
                       (r_rd_ptr != r_commit_ptr);
  assign w_release   = w_pop && w_last_lane && w_rd_word.eof;

  // ---------------------------------------------------------------------------
  // Storage write
  // NOTE: the data array has no reset; pointers alone define which entries
  // are live, and leaving it unreset lets it map onto plain RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_base[FIFO_DEPTH-1:0]] <= {data_in_start, data_in_end, data_in};
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // NOTE: every register here uses <= so all branches see pre-edge values,
  // which is what lets write, commit, pop and release share one edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr          <= '0;
      r_frame_start_ptr <= '0;
      r_commit_ptr      <= '0;
      r_in_frame        <= 1'b0;
      r_overflow        <= 1'b0;
      r_rd_ptr          <= '0;
      r_release_ptr     <= '0;
      r_lane            <= '0;
      r_out_active      <= 1'b0;
      r_data_out        <= '0;
      r_data_out_valid  <= 1'b0;
      r_data_out_start  <= 1'b0;
      r_data_out_end    <= 1'b0;
      r_frame_count     <= '0;
      r_overflow_drop   <= 1'b0;
    end else begin
      r_overflow_drop <= w_discard;

      // Input side
      if (data_in_abort) begin
        if (r_in_frame) begin
          r_wr_ptr   <= r_frame_start_ptr;
          r_in_frame <= 1'b0;
          r_overflow <= 1'b0;
        end
      end else if (w_accept) begin
        r_frame_start_ptr <= w_new_start;
        if (data_in_end) begin
          r_in_frame <= 1'b0;
          r_overflow <= 1'b0;
          if (w_drop) begin
            r_wr_ptr <= w_new_start;
          end else begin
            r_wr_ptr     <= w_base_inc;
            r_commit_ptr <= w_base_inc;
          end
        end else begin
          r_in_frame <= 1'b1;
          r_overflow <= w_drop;
          r_wr_ptr   <= w_drop ? w_base : w_base_inc;
        end
      end

      // Output side
      if (w_out_retry) begin
        r_rd_ptr         <= r_release_ptr;
        r_lane           <= '0;
        r_out_active     <= 1'b0;
        r_data_out_valid <= 1'b0;
        r_data_out_start <= 1'b0;
        r_data_out_end   <= 1'b0;
      end else if (w_pop) begin
        r_data_out       <= w_beat;
        r_data_out_valid <= 1'b1;
        r_data_out_start <= w_rd_word.sof && (r_lane == '0);
        r_data_out_end   <= w_rd_word.eof && w_last_lane;
        if (w_last_lane) begin
          r_lane   <= '0;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end else begin
          r_lane <= r_lane + 1'b1;
        end
        if (w_release) begin
          r_release_ptr <= r_rd_ptr + 1'b1;
          r_out_active  <= 1'b0;
        end else begin
          r_out_active <= 1'b1;
        end
      end else begin
        r_data_out_valid <= 1'b0;
        r_data_out_start <= 1'b0;
        r_data_out_end   <= 1'b0;
      end

      // Committed-frame count: nets commit against release, saturating.
      if (w_commit && !w_release && (r_frame_count != COUNT_MAX)) begin
        r_frame_count <= r_frame_count + 1'b1;
      end else if (w_release && !w_commit && (r_frame_count != '0)) begin
        r_frame_count <= r_frame_count - 1'b1;
      end
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign data_out_start = r_data_out_start;
  assign data_out_end   = r_data_out_end;
  assign frame_count    = r_frame_count;
  assign overflow_drop  = r_overflow_drop;
  assign fifo_full      = (w_used == PTR_ENTRIES);

endmodule

// File: tb/tb_mac_frame_fifo.sv
// -----------------------------------------------------------------------------
// tb_mac_frame_fifo
//   Self-checking bench for mac_frame_fifo. A default instance (32->8, 16
//   words) runs a vector table, directed multi-cycle sequences and a random
//   run checked against a queue-based frame model. A second instance with
//   FIFO_DEPTH=2 covers the overflow/drop behaviour.
// -----------------------------------------------------------------------------
module tb_mac_frame_fifo;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Default instance
  logic        reset;
  logic [31:0] data_in;
  logic        data_in_enable, data_in_start, data_in_end, data_in_abort;
  logic [7:0]  data_out;
  logic        data_out_enable, data_out_valid, data_out_start, data_out_end;
  logic        retry, fifo_full, overflow_drop;
  logic [3:0]  frame_count;

  // Small instance (4 words)
  logic        reset_b;
  logic [31:0] data_in_b;
  logic        data_in_enable_b, data_in_start_b, data_in_end_b, data_in_abort_b;
  logic [7:0]  data_out_b;
  logic        data_out_enable_b, data_out_valid_b, data_out_start_b, data_out_end_b;
  logic        retry_b, fifo_full_b, overflow_drop_b;
  logic [3:0]  frame_count_b;

  mac_frame_fifo dut (
    .clock(clock), .reset(reset),
    .data_in(data_in), .data_in_enable(data_in_enable),
    .data_in_start(data_in_start), .data_in_end(data_in_end),
    .data_in_abort(data_in_abort),
    .data_out(data_out), .data_out_enable(data_out_enable),
    .data_out_valid(data_out_valid), .data_out_start(data_out_start),
    .data_out_end(data_out_end), .retry(retry),
    .fifo_full(fifo_full), .frame_count(frame_count),
    .overflow_drop(overflow_drop)
  );

  mac_frame_fifo #(.FIFO_DEPTH(2)) dut_small (
    .clock(clock), .reset(reset_b),
    .data_in(data_in_b), .data_in_enable(data_in_enable_b),
    .data_in_start(data_in_start_b), .data_in_end(data_in_end_b),
    .data_in_abort(data_in_abort_b),
    .data_out(data_out_b), .data_out_enable(data_out_enable_b),
    .data_out_valid(data_out_valid_b), .data_out_start(data_out_start_b),
    .data_out_end(data_out_end_b), .retry(retry_b),
    .fifo_full(fifo_full_b), .frame_count(frame_count_b),
    .overflow_drop(overflow_drop_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    data_in = '0; data_in_enable = 0; data_in_start = 0; data_in_end = 0;
    data_in_abort = 0; data_out_enable = 0; retry = 0;
  endtask

  task automatic idle_b();
    data_in_b = '0; data_in_enable_b = 0; data_in_start_b = 0; data_in_end_b = 0;
    data_in_abort_b = 0; data_out_enable_b = 0; retry_b = 0;
  endtask

  task automatic push_a(input logic [31:0] d, input logic s, input logic e);
    data_in = d; data_in_enable = 1; data_in_start = s; data_in_end = e;
    tick();
    idle_a();
  endtask

  task automatic push_b(input logic [31:0] d, input logic s, input logic e);
    data_in_b = d; data_in_enable_b = 1; data_in_start_b = s; data_in_end_b = e;
    tick();
    idle_b();
  endtask

  // Beat k of the frame {1,2,3} serialised MSB first.
  function automatic logic [7:0] exp_beat(input int k);
    return (k % 4 == 3) ? 8'(k / 4 + 1) : 8'h00;
  endfunction

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we, sof, eof, abort;
    logic [31:0] din;
    logic        pop, rty;
    logic        e_valid;
    logic [7:0]  e_dout;
    logic        e_sof, e_eof;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, sof, eof, abort, input logic [31:0] din,
                              input logic pop, rty, e_valid, input logic [7:0] e_dout,
                              input logic e_sof, e_eof, input logic [3:0] e_cnt);
    vec_t v;
    v.we = we; v.sof = sof; v.eof = eof; v.abort = abort; v.din = din;
    v.pop = pop; v.rty = rty; v.e_valid = e_valid; v.e_dout = e_dout;
    v.e_sof = e_sof; v.e_eof = e_eof; v.e_cnt = e_cnt;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: committed frames as a word queue plus a length queue.
  // ---------------------------------------------------------------------------
  logic [31:0] m_words[$];
  int          m_len[$];
  logic [31:0] m_pend[$];
  bit          m_in_frame, m_ovf;
  int          m_pos;
  logic [7:0]  m_dout;

  task automatic model_reset();
    m_words.delete(); m_len.delete(); m_pend.delete();
    m_in_frame = 0; m_ovf = 0; m_pos = 0; m_dout = 8'h00;
  endtask

  // Returns {valid, sof, eof, dout, count, full, ovf_drop} expected after the edge.
  task automatic model_step(input logic we, sof, eof, abort, input logic [31:0] din,
                            input logic pop, rty, output logic [16:0] exp);
    int          committed_words, pend_words, base_used, flen;
    logic [31:0] word, tmp;
    bit          v, s, e, drop, ovfd;
    committed_words = m_words.size();
    pend_words      = m_pend.size();
    v = 0; s = 0; e = 0; ovfd = 0;

    // Output side uses only pre-edge frames.
    if (rty && m_pos > 0) begin
      m_pos = 0;
    end else if (pop && m_len.size() > 0) begin
      flen   = m_len[0];
      word   = m_words[m_pos / 4];
      tmp    = word >> (8 * (3 - m_pos % 4));
      m_dout = tmp[7:0];
      v = 1;
      s = (m_pos == 0);
      e = (m_pos == 4 * flen - 1);
      m_pos++;
      if (e) begin
        for (int i = 0; i < flen; i++) void'(m_words.pop_front());
        void'(m_len.pop_front());
        m_pos = 0;
      end
    end

    // Input side; space is judged on pre-edge occupancy.
    if (abort) begin
      if (m_in_frame) begin
        m_pend.delete(); m_in_frame = 0; m_ovf = 0;
      end
    end else if (we && (sof || m_in_frame)) begin
      base_used = committed_words + (sof ? 0 : pend_words);
      if (sof) m_pend.delete();
      drop = (base_used == 16) || (m_ovf && !sof);
      if (!drop) m_pend.push_back(din);
      if (eof) begin
        if (drop) begin
          ovfd = 1;
        end else begin
          foreach (m_pend[i]) m_words.push_back(m_pend[i]);
          m_len.push_back(m_pend.size());
        end
        m_pend.delete();
        m_in_frame = 0; m_ovf = 0;
      end else begin
        m_in_frame = 1; m_ovf = drop;
      end
    end

    exp = {v, s, e, m_dout, 4'(m_len.size()),
           ((m_words.size() + m_pend.size()) == 16), ovfd};
  endtask

  initial begin
    logic [16:0] exp_vec, got_vec;
    bit   g_in;
    int   g_left, pop_pct;
    logic we, sof, eof, abort, pop, rty;
    logic [31:0] din;

    idle_a();
    idle_b();
    reset = 1; reset_b = 1;
    tick(); tick();
    reset = 0; reset_b = 0;

    // Reset state
    check("rst_valid", data_out_valid, 0);
    check("rst_dout",  data_out, 0);
    check("rst_sof",   data_out_start, 0);
    check("rst_eof",   data_out_end, 0);
    check("rst_count", frame_count, 0);
    check("rst_full",  fifo_full, 0);
    check("rst_ovf",   overflow_drop, 0);
    check("rst_full_small", fifo_full_b, 0);

    // Three-word frame then 12 pops, a pop while empty, abort and one-word frame.
    vecs.push_back(mk(1, 1, 0, 0, 32'h1, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h2, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h3, 0, 0, 0, 8'h00, 0, 0, 1));
    for (int k = 0; k < 12; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, exp_beat(k), k == 0, k == 11,
                        (k == 11) ? 4'd0 : 4'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h03, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'hAABBCCDD, 0, 0, 0, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 8'h03, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h03, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h11223344, 0, 0, 0, 8'h03, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 8'h11, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 8'h22, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 8'h33, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 8'h44, 0, 1, 0));

    foreach (vecs[i]) begin
      data_in = vecs[i].din; data_in_enable = vecs[i].we;
      data_in_start = vecs[i].sof; data_in_end = vecs[i].eof;
      data_in_abort = vecs[i].abort; data_out_enable = vecs[i].pop;
      retry = vecs[i].rty;
      tick();
      check($sformatf("vec%0d_valid", i), data_out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_dout", i),  data_out, vecs[i].e_dout);
      check($sformatf("vec%0d_sof", i),   data_out_start, vecs[i].e_sof);
      check($sformatf("vec%0d_eof", i),   data_out_end, vecs[i].e_eof);
      check($sformatf("vec%0d_count", i), frame_count, vecs[i].e_cnt);
    end
    idle_a();

    // Retry mid-frame: 6 beats, retry, then the whole frame again.
    push_a(32'h1, 1, 0);
    push_a(32'h2, 0, 0);
    push_a(32'h3, 0, 1);
    data_out_enable = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("retry_pre%0d_dout", k), data_out, exp_beat(k));
    end
    retry = 1;
    tick();
    retry = 0;
    check("retry_edge_valid", data_out_valid, 0);
    check("retry_edge_count", frame_count, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("retry_post%0d", k),
            {data_out_valid, data_out_start, data_out_end, data_out, frame_count},
            {1'b1, k == 0, k == 11, exp_beat(k), (k == 11) ? 4'd0 : 4'd1});
    end
    // Retry between frames is ignored; pop on empty stays invalid.
    retry = 1;
    tick();
    retry = 0;
    check("retry_idle_valid", data_out_valid, 0);
    check("retry_idle_dout", data_out, 8'h03);
    idle_a();

    // Reset in the middle of reading a committed frame.
    push_a(32'h1, 1, 0);
    push_a(32'h2, 0, 1);
    data_out_enable = 1;
    tick(); tick(); tick();
    check("midpop_valid", data_out_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    check("rst2_all", {data_out_valid, data_out_start, data_out_end, data_out,
                       frame_count, fifo_full, overflow_drop}, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rst2_pop%0d_valid", k), data_out_valid, 0);
    end
    idle_a();

    // Overflow on the 4-word instance.
    for (int k = 0; k < 4; k++) begin
      push_b(32'h10 + k, k == 0, 0);
      check($sformatf("ovf_full%0d", k), fifo_full_b, k == 3);
      check($sformatf("ovf_pulse%0d", k), overflow_drop_b, 0);
    end
    push_b(32'h14, 0, 1);
    check("ovf_pulse_end", overflow_drop_b, 1);
    check("ovf_count_end", frame_count_b, 0);
    check("ovf_full_after", fifo_full_b, 0);
    tick();
    check("ovf_pulse_gone", overflow_drop_b, 0);
    push_b(32'hA1A2A3A4, 1, 0);
    push_b(32'hB1B2B3B4, 0, 1);
    check("ovf_next_count", frame_count_b, 1);
    data_out_enable_b = 1;
    for (int k = 0; k < 8; k++) begin
      logic [63:0] fr;
      logic [7:0]  eb;
      fr = 64'hA1A2A3A4B1B2B3B4;
      eb = fr[63 - 8 * k -: 8];
      tick();
      check($sformatf("ovf_next_beat%0d", k),
            {data_out_valid_b, data_out_start_b, data_out_end_b, data_out_b},
            {1'b1, k == 0, k == 7, eb});
    end
    idle_b();
    tick();
    check("ovf_next_released", frame_count_b, 0);

    // Random run against the model.
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    g_in = 0; g_left = 0;
    for (int c = 0; c < 4000; c++) begin
      case ((c / 500) % 4)
        0: pop_pct = 80;
        1: pop_pct = 15;
        2: pop_pct = 60;
        default: pop_pct = 5;
      endcase
      we    = ($urandom % 3) != 0;
      abort = ($urandom % 50) == 0;
      rty   = ($urandom % 30) == 0;
      pop   = ($urandom % 100) < pop_pct;
      din   = $urandom;
      sof = 0; eof = 0;
      if (we) begin
        if (!g_in) begin
          if (($urandom % 10) != 0) begin
            sof = 1; g_in = 1; g_left = $urandom_range(6, 2) - 1;
          end
        end else if (($urandom % 40) == 0) begin
          sof = 1; g_left = $urandom_range(6, 2) - 1;
        end else begin
          g_left--;
          if (g_left == 0) begin
            eof = 1; g_in = 0;
          end
        end
      end
      if (abort) g_in = 0;

      data_in = din; data_in_enable = we; data_in_start = sof; data_in_end = eof;
      data_in_abort = abort; data_out_enable = pop; retry = rty;
      model_step(we, sof, eof, abort, din, pop, rty, exp_vec);
      tick();
      got_vec = {data_out_valid, data_out_start, data_out_end, data_out,
                 frame_count, fifo_full, overflow_drop};
      check($sformatf("rand_c%0d", c), 32'(got_vec), 32'(exp_vec));
    end
    idle_a();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
